// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and counter-width helper for the PISO shifter
package piso_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// piso_bitcnt: loadable down-counter of remaining bits, flags the last bit (count==1)
module piso_bitcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = piso_pkg::cnt_width(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld,
    input  logic dec,
    output logic last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load wins over decrement so a back-to-back word restarts the count
    always_comb begin
        cnt_d = ld ? CNT_W'(WIDTH) : dec ? cnt_q - CNT_W'(1) : cnt_q;
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign last = cnt_q == CNT_W'(1);

endmodule

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in/serial-out shifter with load/ready handshake, MSB/LSB order,
// valid strobe and last-bit done pulse. Define PISO_PARITY_EN to append an even-parity bit.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pi,
    input  logic             load,
    input  logic             msb_first,
    output logic             ready,
    output logic             so,
    output logic             so_valid,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             msb_q;
    logic             msb_d;
    logic             last;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q;
    logic             par_d;
`endif

    piso_bitcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (accept),
        .dec   (state_q == S_SHIFT),
        .last  (last)
    );

    // outputs decoded only from registered state, counter flag and shift register
    always_comb begin
        so       = 1'b0;
        so_valid = 1'b0;
        done     = 1'b0;
        ready    = state_q == S_IDLE;
        if (state_q == S_SHIFT) begin
            so       = msb_q ? sr_q[WIDTH-1] : sr_q[0];
            so_valid = 1'b1;
`ifdef PISO_PARITY_EN
            done     = 1'b0;
`else
            done     = last;
            ready    = last;
`endif
        end
`ifdef PISO_PARITY_EN
        if (state_q == S_PARITY) begin
            so       = par_q;
            so_valid = 1'b1;
            done     = 1'b1;
        end
`endif
    end

    // next state and datapath; an accepted load overrides the shift on the last bit
    always_comb begin
        accept  = load && ready;
        state_d = state_q;
        sr_d    = sr_q;
        msb_d   = msb_q;
`ifdef PISO_PARITY_EN
        par_d   = accept ? ^pi : par_q;
`endif
        case (state_q)
            S_IDLE:  state_d = accept ? S_SHIFT : S_IDLE;
            S_SHIFT: begin
                sr_d = msb_q ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
`ifdef PISO_PARITY_EN
                state_d = last ? S_PARITY : S_SHIFT;
`else
                state_d = (last && !accept) ? S_IDLE : S_SHIFT;
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            sr_d  = pi;
            msb_d = msb_first;
        end
    end

    // state and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            msb_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            msb_q   <= msb_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: directed self-checking bench for piso_shifter at WIDTH=4 and WIDTH=8
module tb_piso_shifter;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pi4 = '0;
    logic       load4 = 1'b0;
    logic       msb4 = 1'b0;
    logic       ready4, so4, v4, done4;
    logic [7:0] pi8 = '0;
    logic       load8 = 1'b0;
    logic       msb8 = 1'b0;
    logic       ready8, so8, v8, done8;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pi(pi4), .load(load4), .msb_first(msb4),
        .ready(ready4), .so(so4), .so_valid(v4), .done(done4)
    );

    piso_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .pi(pi8), .load(load8), .msb_first(msb8),
        .ready(ready8), .so(so8), .so_valid(v8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4(input string tag);
        check({tag, " ready"}, ready4, 1'b1);
        check({tag, " so"}, so4, 1'b0);
        check({tag, " so_valid"}, v4, 1'b0);
        check({tag, " done"}, done4, 1'b0);
    endtask

    // exp lists the serial bits in output order, exp[3] first; busy drives an ignored load of 4'hF
    task automatic word4(input string tag, input logic [3:0] p, input logic m,
                         input logic [3:0] exp, input logic par, input logic busy);
        load4 = 1'b1;
        pi4   = p;
        msb4  = m;
        tick();
        for (int k = 0; k < 4; k++) begin
            load4 = busy && (k < 3);
            pi4   = 4'hF;
            msb4  = ~m;
            check($sformatf("%s so[%0d]", tag, k), so4, exp[3-k]);
            check($sformatf("%s valid[%0d]", tag, k), v4, 1'b1);
            check($sformatf("%s done[%0d]", tag, k), done4, (k == 3) && !PAR);
            check($sformatf("%s ready[%0d]", tag, k), ready4, (k == 3) && !PAR);
            tick();
        end
        load4 = 1'b0;
`ifdef PISO_PARITY_EN
        check({tag, " parity so"}, so4, par);
        check({tag, " parity valid"}, v4, 1'b1);
        check({tag, " parity done"}, done4, 1'b1);
        check({tag, " parity ready"}, ready4, 1'b0);
        tick();
`else
        check({tag, " no parity bit"}, v4 | par, par);
`endif
        idle4({tag, " after"});
    endtask

    initial begin
        #2;
        idle4("reset4");
        check("reset8 ready", ready8, 1'b1);
        check("reset8 so_valid", v8, 1'b0);
        check("reset8 done", done8, 1'b0);
        #10;
        rst_n = 1'b1;
        tick();
        idle4("post-reset4");

        word4("msb1101", 4'b1101, 1'b1, 4'b1101, 1'b1, 1'b0);
        word4("lsb1010", 4'b1010, 1'b0, 4'b0101, 1'b0, 1'b0);
        word4("busy0110", 4'b0110, 1'b1, 4'b0110, 1'b0, 1'b1);

`ifndef PISO_PARITY_EN
        begin
            logic [15:0] seq;
            seq   = 16'b10100101_00111100;
            load8 = 1'b1;
            pi8   = 8'hA5;
            msb8  = 1'b1;
            tick();
            for (int k = 0; k < 16; k++) begin
                load8 = (k == 7);
                pi8   = (k == 7) ? 8'h3C : 8'h00;
                check($sformatf("b2b so[%0d]", k), so8, seq[15-k]);
                check($sformatf("b2b valid[%0d]", k), v8, 1'b1);
                check($sformatf("b2b done[%0d]", k), done8, (k == 7) || (k == 15));
                check($sformatf("b2b ready[%0d]", k), ready8, (k == 7) || (k == 15));
                tick();
            end
            load8 = 1'b0;
            check("b2b end valid", v8, 1'b0);
            check("b2b end ready", ready8, 1'b1);
        end
`endif

        load4 = 1'b1;
        pi4   = 4'b1101;
        msb4  = 1'b1;
        tick();
        load4 = 1'b0;
        check("abort so[0]", so4, 1'b1);
        tick();
        check("abort so[1]", so4, 1'b1);
        rst_n = 1'b0;
        #1;
        idle4("abort");
        #20;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("abort quiet valid[%0d]", k), v4, 1'b0);
            check($sformatf("abort quiet done[%0d]", k), done4, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parametrised parallel-in/serial-out shifter; next generation of the fixed 4-bit PISO. It accepts a WIDTH-bit word through a load/ready handshake and serialises it MSB-first or LSB-first, one bit per clock. It qualifies each output bit with a valid strobe and flags the final bit. It sits between a parallel data source and any single-wire serial sink in the design.

## Interface
- WIDTH, 8: word width in bits, legal range 2..32.
- CNT_W, $clog2(WIDTH+1): bit-counter width. Derived; do not override.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- pi  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  load request; accepted when load && ready at a clk rising edge.
- msb_first  input  1  shift order, sampled with pi on accept: 1 = bit WIDTH-1 first, 0 = bit 0 first.
- ready  output  1  block can accept a word this cycle.
- so  output  1  serial data bit.
- so_valid  output  1  so carries a valid bit this cycle.
- done  output  1  one-cycle pulse coincident with the last serial bit of a word.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY only with PISO_PARITY_EN).
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, counter=0, so=0, so_valid=0, done=0, ready=1.
- IDLE: ready=1, so_valid=0, so=0. An accepted load captures pi, captures msb_first, loads counter=WIDTH, and moves to SHIFT.
- SHIFT:
  - so_valid=1; so = current head bit (bit WIDTH-1 for MSB-first, bit 0 for LSB-first).
  - Each cycle the register shifts toward the head, zero fill, and the counter decrements.
  - Counter==1 marks the last bit. done=1 on that cycle.
  - Last bit without parity: next state IDLE, unless a load is accepted that same cycle; then the block reloads and stays in SHIFT.
- Back-to-back: without parity, ready=1 on the last-bit cycle of SHIFT, so consecutive words stream with no gap. ready=0 on all other SHIFT cycles.
- Load while ready=0: ignored. No state change and no error.
- pi and msb_first changing after accept have no effect on the word in flight.
- Reset mid-word: aborts immediately. The partial word is lost and there is no done pulse.

## Timing
- Latency: load accepted at edge N → first bit on so/so_valid during cycle N+1. The last bit and done appear in cycle N+WIDTH.
- One word occupies WIDTH cycles, or WIDTH+1 cycles with parity.
- Sustained throughput: 1 bit/clk without parity. With parity there is one extra cycle plus one IDLE cycle per word.
- All outputs are registered or decoded only from state and counter. No combinational path from load or pi to any output.

## Configuration
- PISO_PARITY_EN defined:
  - After the last data bit, the block enters PARITY for one cycle: so = even parity (XOR of captured pi), so_valid=1.
  - done moves to the parity cycle.
  - ready stays 0 through PARITY, then the block returns to IDLE.
- PISO_PARITY_EN undefined: no PARITY state, no parity logic, and back-to-back streaming as above.

## Structure
- Shared package piso_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_SHIFT=2'd1, S_PARITY=2'd2;
  - the CNT_W derivation function.
- One natural sub-module, piso_bitcnt: a loadable down-counter with a last flag (count==1). The FSM and shift register stay in piso_shifter.

## Test plan
- Reset: rst_n=0 mid-SHIFT of 4'b1101 (WIDTH=4) → so=0, so_valid=0, done=0, ready=1 immediately; no further bits.
- WIDTH=4, msb_first=1, pi=4'b1101 → so=1,1,0,1 in cycles N+1..N+4; done only in N+4; ready=1 again in N+4.
- WIDTH=4, msb_first=0, pi=4'b1010 → so=0,1,0,1; so_valid high for exactly 4 cycles.
- Back-to-back, WIDTH=8: 8'hA5 then 8'h3C loaded on the last-bit cycle → 16 contiguous valid bits 10100101_00111100; two done pulses.
- Load asserted with pi=4'hF while busy (ready=0) → ignored; the in-flight word completes unchanged.
- PISO_PARITY_EN, WIDTH=4, pi=4'b1101, MSB-first → so=1,1,0,1,1 (parity); done on the 5th bit; ready=0 throughout SHIFT and PARITY.
